// File: rtl/alu_bist_if.sv
// Bus between the ALU self-test engine and its surroundings: run handshake,
// status/report outputs, the directed-vector read port and both ALUs.
interface alu_bist_if #(
  parameter int N        = 32,
  parameter int N_VECTOR = 9
);
  localparam int AW = (N_VECTOR > 1) ? $clog2(N_VECTOR) : 1;

  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic          aborted;
  logic [15:0]   error_count;
  logic [15:0]   fail_op_mask;
  logic [N-1:0]  first_fail_a;
  logic [N-1:0]  first_fail_b;
  logic [3:0]    first_fail_control;

  logic [AW-1:0] vec_addr_a;
  logic [AW-1:0] vec_addr_b;
  logic [N-1:0]  vec_data_a;
  logic [N-1:0]  vec_data_b;

  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic [3:0]    control;
  logic [N-1:0]  dut_result;
  logic [N-1:0]  ref_result;
  logic          dut_overflow;
  logic          dut_zero;
  logic          dut_equal;
  logic          ref_overflow;
  logic          ref_zero;
  logic          ref_equal;

  // The self-test engine drives stimulus and status.
  modport master (
    input  start, vec_data_a, vec_data_b,
           dut_result, ref_result,
           dut_overflow, dut_zero, dut_equal,
           ref_overflow, ref_zero, ref_equal,
    output busy, done, pass, aborted, error_count, fail_op_mask,
           first_fail_a, first_fail_b, first_fail_control,
           vec_addr_a, vec_addr_b, a, b, control
  );

  // The environment: vector store, both ALUs and whoever launches runs.
  modport slave (
    output start, vec_data_a, vec_data_b,
           dut_result, ref_result,
           dut_overflow, dut_zero, dut_equal,
           ref_overflow, ref_zero, ref_equal,
    input  busy, done, pass, aborted, error_count, fail_op_mask,
           first_fail_a, first_fail_b, first_fail_control,
           vec_addr_a, vec_addr_b, a, b, control
  );
endinterface

// File: rtl/alu_bist.sv
// ALU self-test engine: for every enabled control code it applies a directed
// cross-product of stored vectors and then LFSR random pairs to a DUT ALU and
// a reference ALU, counts field mismatches and records the first failure.
module alu_bist #(
  parameter int          N          = 32,
  parameter int          N_VECTOR   = 9,
  parameter int          N_RANDOM   = 25,
  parameter int          MAX_ERRORS = 10,
  parameter logic [15:0] OP_MASK    = 16'h03FF,
  parameter logic [31:0] SEED       = 32'h0000_0001
) (
  input logic        clk,
  input logic        rst,
  alu_bist_if.master bus
);
  localparam int AW = (N_VECTOR > 1) ? $clog2(N_VECTOR) : 1;
  localparam int RW = (N_RANDOM > 1) ? $clog2(N_RANDOM) : 1;
  localparam logic [AW-1:0] LAST_VEC = AW'(N_VECTOR - 1);
  localparam logic [RW-1:0] LAST_RND = RW'((N_RANDOM > 0) ? N_RANDOM - 1 : 0);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t        state;
  logic [31:0]   lfsr;
  logic [AW-1:0] j;
  logic [AW-1:0] k;
  logic [RW-1:0] rnd_cnt;
  logic          random_phase;
  logic [3:0]    cur_op;

  logic [31:0]   lfsr_s1;
  logic [31:0]   lfsr_s2;
  logic [4:0]    first_op;
  logic [4:0]    next_op;
  logic          op_end;
  logic [3:0]    miss;
  logic [2:0]    n_miss;
  logic [16:0]   sum;
  logic [15:0]   new_count;
  logic          over_limit;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  // Returns {found, code} for the lowest enabled control code >= from.
  function automatic logic [4:0] find_op(input int from);
    logic [4:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (i >= from && OP_MASK[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  assign bus.vec_addr_a = j;
  assign bus.vec_addr_b = k;

  // Mismatch detection, saturating error sum and sweep-position decode.
  always_comb begin
    lfsr_s1    = lfsr_next(lfsr);
    lfsr_s2    = lfsr_next(lfsr_s1);
    first_op   = find_op(0);
    next_op    = find_op(int'(cur_op) + 1);
    op_end     = random_phase ? (rnd_cnt == LAST_RND)
                              : (j == LAST_VEC && k == LAST_VEC && N_RANDOM == 0);
    miss       = {bus.dut_result   !== bus.ref_result,
                  bus.dut_overflow !== bus.ref_overflow,
                  bus.dut_zero     !== bus.ref_zero,
                  bus.dut_equal    !== bus.ref_equal};
    n_miss     = {2'b0, miss[0]} + {2'b0, miss[1]} + {2'b0, miss[2]} + {2'b0, miss[3]};
    sum        = {1'b0, bus.error_count} + {14'b0, n_miss};
    new_count  = sum[16] ? 16'hFFFF : sum[15:0];
    over_limit = int'({16'h0, new_count}) > MAX_ERRORS;
  end

  // Run sequencer: launch, apply/check vector pairs, sweep codes, finish or abort.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state                  <= IDLE;
      lfsr                   <= SEED;
      j                      <= '0;
      k                      <= '0;
      rnd_cnt                <= '0;
      random_phase           <= 1'b0;
      cur_op                 <= '0;
      bus.busy               <= 1'b0;
      bus.done               <= 1'b0;
      bus.pass               <= 1'b0;
      bus.aborted            <= 1'b0;
      bus.error_count        <= '0;
      bus.fail_op_mask       <= '0;
      bus.first_fail_a       <= '0;
      bus.first_fail_b       <= '0;
      bus.first_fail_control <= '0;
      bus.a                  <= '0;
      bus.b                  <= '0;
      bus.control            <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            bus.error_count        <= '0;
            bus.fail_op_mask       <= '0;
            bus.first_fail_a       <= '0;
            bus.first_fail_b       <= '0;
            bus.first_fail_control <= '0;
            bus.aborted            <= 1'b0;
            j                      <= '0;
            k                      <= '0;
            rnd_cnt                <= '0;
            random_phase           <= 1'b0;
            if (first_op[4]) begin
              cur_op   <= first_op[3:0];
              bus.busy <= 1'b1;
              bus.done <= 1'b0;
              bus.pass <= 1'b0;
              state    <= APPLY;
            end else begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= 1'b1;
              state    <= DONE;
            end
          end
        end
        APPLY: begin
          bus.control <= cur_op;
          if (random_phase) begin
            bus.a <= lfsr[N-1:0];
            bus.b <= lfsr_s1[N-1:0];
            lfsr  <= lfsr_s2;
          end else begin
            bus.a <= bus.vec_data_a;
            bus.b <= bus.vec_data_b;
          end
          state <= CHECK;
        end
        CHECK: begin
          bus.error_count <= new_count;
          if (|miss) begin
            bus.fail_op_mask[bus.control] <= 1'b1;
            if (bus.error_count == '0) begin
              bus.first_fail_a       <= bus.a;
              bus.first_fail_b       <= bus.b;
              bus.first_fail_control <= bus.control;
            end
          end
          if (over_limit) begin
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.pass    <= 1'b0;
            bus.aborted <= 1'b1;
            state       <= DONE;
          end else if (op_end) begin
            if (next_op[4]) begin
              cur_op       <= next_op[3:0];
              random_phase <= 1'b0;
              j            <= '0;
              k            <= '0;
              rnd_cnt      <= '0;
              state        <= APPLY;
            end else begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= (new_count == '0);
              state    <= DONE;
            end
          end else begin
            state <= APPLY;
            if (random_phase) begin
              rnd_cnt <= rnd_cnt + 1'b1;
            end else if (k == LAST_VEC) begin
              k <= '0;
              if (j == LAST_VEC) begin
                j            <= '0;
                random_phase <= 1'b1;
                rnd_cnt      <= '0;
              end else begin
                j <= j + 1'b1;
              end
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: three engines share one clock and reset
// (default setup with optional zero-flag fault, control-3 result fault with a
// large error limit, and an empty op mask). Expected stimulus for the main
// engine is generated into a queue when a run is launched and popped as each
// vector appears on a/b/control.
module tb_alu_bist;
  localparam int          N         = 32;
  localparam logic [15:0] MAIN_MASK = 16'h03FF;
  localparam logic [31:0] SEED      = 32'h0000_0001;
  localparam int          RUN_LEN   = 2 * (9 * 9 + 25) * 10 + 1;
  localparam int          LIMIT     = 6000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
  } stim_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  fault_zero;
  int    tests_run    = 0;
  int    tests_failed = 0;
  int    cycles;
  stim_t exp_q[$];
  stim_t first_zero;
  logic  have_zero;
  logic [31:0] model_lfsr;

  always #5 clk = ~clk;

  alu_bist_if #(.N(N), .N_VECTOR(9)) bus_m ();
  alu_bist_if #(.N(N), .N_VECTOR(9)) bus_b ();
  alu_bist_if #(.N(N), .N_VECTOR(9)) bus_z ();

  alu_bist #(.N(N), .N_VECTOR(9), .N_RANDOM(25), .MAX_ERRORS(10),
             .OP_MASK(MAIN_MASK), .SEED(SEED))
    u_main (.clk(clk), .rst(rst), .bus(bus_m));
  alu_bist #(.N(N), .N_VECTOR(9), .N_RANDOM(25), .MAX_ERRORS(65535),
             .OP_MASK(MAIN_MASK), .SEED(SEED))
    u_big (.clk(clk), .rst(rst), .bus(bus_b));
  alu_bist #(.N(N), .N_VECTOR(9), .N_RANDOM(25), .MAX_ERRORS(10),
             .OP_MASK(16'h0000), .SEED(SEED))
    u_zero (.clk(clk), .rst(rst), .bus(bus_z));

  function automatic logic [31:0] vec_rom(input logic [3:0] i);
    case (i)
      4'd0: return 32'h0000_0001;
      4'd1: return 32'h0000_0000;
      4'd2: return 32'hFFFF_FFFF;
      4'd3: return 32'h7FFF_FFFF;
      4'd4: return 32'h8000_0000;
      4'd5: return 32'h1234_5678;
      4'd6: return 32'h0000_0005;
      4'd7: return 32'hAAAA_AAAA;
      4'd8: return 32'h5555_5555;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] alu_res(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] c);
    case (c)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return ~(x | y);
      4'd6: return x << y[4:0];
      4'd7: return x >> y[4:0];
      4'd8: return $unsigned($signed(x) >>> y[4:0]);
      4'd9: return {31'b0, ($signed(x) < $signed(y))};
      default: return x;
    endcase
  endfunction

  function automatic logic alu_ovf(input logic [31:0] x, input logic [31:0] y,
                                   input logic [3:0] c);
    logic [31:0] r;
    r = alu_res(x, y, c);
    if (c == 4'd0) return (x[31] == y[31]) && (r[31] != x[31]);
    if (c == 4'd1) return (x[31] != y[31]) && (r[31] != x[31]);
    return 1'b0;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  // Main engine: healthy ALU apart from an optional stuck-at-0 zero flag.
  assign bus_m.vec_data_a   = vec_rom(bus_m.vec_addr_a);
  assign bus_m.vec_data_b   = vec_rom(bus_m.vec_addr_b);
  assign bus_m.ref_result   = alu_res(bus_m.a, bus_m.b, bus_m.control);
  assign bus_m.ref_overflow = alu_ovf(bus_m.a, bus_m.b, bus_m.control);
  assign bus_m.ref_zero     = (bus_m.ref_result == 32'h0);
  assign bus_m.ref_equal    = (bus_m.a == bus_m.b);
  assign bus_m.dut_result   = alu_res(bus_m.a, bus_m.b, bus_m.control);
  assign bus_m.dut_overflow = alu_ovf(bus_m.a, bus_m.b, bus_m.control);
  assign bus_m.dut_zero     = fault_zero ? 1'b0 : (bus_m.dut_result == 32'h0);
  assign bus_m.dut_equal    = (bus_m.a == bus_m.b);

  // Large-limit engine: DUT result bit 0 flipped whenever control is 3.
  assign bus_b.vec_data_a   = vec_rom(bus_b.vec_addr_a);
  assign bus_b.vec_data_b   = vec_rom(bus_b.vec_addr_b);
  assign bus_b.ref_result   = alu_res(bus_b.a, bus_b.b, bus_b.control);
  assign bus_b.ref_overflow = alu_ovf(bus_b.a, bus_b.b, bus_b.control);
  assign bus_b.ref_zero     = (bus_b.ref_result == 32'h0);
  assign bus_b.ref_equal    = (bus_b.a == bus_b.b);
  assign bus_b.dut_result   = bus_b.ref_result ^ ((bus_b.control == 4'd3) ? 32'h1 : 32'h0);
  assign bus_b.dut_overflow = bus_b.ref_overflow;
  assign bus_b.dut_zero     = bus_b.ref_zero;
  assign bus_b.dut_equal    = bus_b.ref_equal;

  // Empty-mask engine: healthy ALU.
  assign bus_z.vec_data_a   = vec_rom(bus_z.vec_addr_a);
  assign bus_z.vec_data_b   = vec_rom(bus_z.vec_addr_b);
  assign bus_z.ref_result   = alu_res(bus_z.a, bus_z.b, bus_z.control);
  assign bus_z.ref_overflow = alu_ovf(bus_z.a, bus_z.b, bus_z.control);
  assign bus_z.ref_zero     = (bus_z.ref_result == 32'h0);
  assign bus_z.ref_equal    = (bus_z.a == bus_z.b);
  assign bus_z.dut_result   = bus_z.ref_result;
  assign bus_z.dut_overflow = bus_z.ref_overflow;
  assign bus_z.dut_zero     = bus_z.ref_zero;
  assign bus_z.dut_equal    = bus_z.ref_equal;

  task automatic checkOutput(input string tag, input logic [67:0] got, input logic [67:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Queue the expected stimulus of a full main-engine run, then pulse start
  // (held for 'hold' cycles) and return right after the start edge.
  task automatic applyStimulus(input int hold);
    logic [31:0] s;
    exp_q.delete();
    for (int op = 0; op < 16; op++) begin
      if (MAIN_MASK[op]) begin
        for (int j = 0; j < 9; j++)
          for (int k = 0; k < 9; k++)
            exp_q.push_back({vec_rom(4'(j)), vec_rom(4'(k)), 4'(op)});
        for (int r = 0; r < 25; r++) begin
          s = lfsr_step(model_lfsr);
          exp_q.push_back({model_lfsr, s, 4'(op)});
          model_lfsr = lfsr_step(s);
        end
      end
    end
    have_zero  = 1'b0;
    first_zero = '0;
    foreach (exp_q[i]) begin
      if (!have_zero && alu_res(exp_q[i].a, exp_q[i].b, exp_q[i].c) == 32'h0) begin
        have_zero  = 1'b1;
        first_zero = exp_q[i];
      end
    end
    @(negedge clk);
    bus_m.start = 1'b1;
    @(posedge clk);
    fork
      begin
        repeat (hold) @(negedge clk);
        bus_m.start = 1'b0;
      end
    join_none
  endtask

  // Follow a main-engine run vector by vector until done or the cycle budget.
  task automatic runMain(input bit check_rand, output int n_cycles);
    stim_t e;
    int    idx;
    n_cycles = 1;
    idx      = 0;
    #1;
    checkOutput("start_flags", 68'({bus_m.busy, bus_m.done, bus_m.pass}), 68'(3'b100));
    while (1) begin
      if (n_cycles >= LIMIT) begin
        checkOutput("timeout_done", 68'(bus_m.done), 68'(1));
        break;
      end
      @(posedge clk); #1; n_cycles++;
      if (exp_q.size() == 0) begin
        checkOutput("extra_vector", 68'(idx), 68'(RUN_LEN / 2));
        break;
      end
      e = exp_q.pop_front();
      checkOutput("stimulus", {bus_m.a, bus_m.b, bus_m.control}, e);
      if (check_rand && idx == 81)
        checkOutput("first_random", {bus_m.a, bus_m.b, bus_m.control},
                    {32'h0000_0001, 32'h8020_0003, 4'h0});
      idx++;
      @(posedge clk); #1; n_cycles++;
      if (bus_m.done) break;
    end
  endtask

  task automatic checkClean(input string tag, input int n_cycles);
    checkOutput({tag, "_cycles"}, 68'(n_cycles), 68'(RUN_LEN));
    checkOutput({tag, "_flags"},
                68'({bus_m.busy, bus_m.done, bus_m.pass, bus_m.aborted}), 68'(4'b0110));
    checkOutput({tag, "_counts"}, 68'({bus_m.error_count, bus_m.fail_op_mask}), 68'(0));
    checkOutput({tag, "_queue_left"}, 68'(exp_q.size()), 68'(0));
  endtask

  initial begin
    rst         = 1'b0;
    fault_zero  = 1'b0;
    bus_m.start = 1'b0;
    bus_b.start = 1'b0;
    bus_z.start = 1'b0;
    model_lfsr  = SEED;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_flags",
                68'({bus_m.busy, bus_m.done, bus_m.pass, bus_m.aborted}), 68'(0));
    checkOutput("reset_counts", 68'({bus_m.error_count, bus_m.fail_op_mask}), 68'(0));
    checkOutput("reset_stim", {bus_m.a, bus_m.b, bus_m.control}, 68'(0));
    checkOutput("reset_first",
                {bus_m.first_fail_a, bus_m.first_fail_b, bus_m.first_fail_control}, 68'(0));
    checkOutput("reset_addr", 68'({bus_m.vec_addr_a, bus_m.vec_addr_b}), 68'(0));
    rst = 1'b1;

    // Clean run from IDLE with start held three cycles.
    applyStimulus(3);
    runMain(1'b1, cycles);
    checkClean("run1", cycles);

    // Relaunch from DONE; the LFSR continues where it stopped.
    applyStimulus(1);
    runMain(1'b0, cycles);
    checkClean("run2", cycles);

    // Reset in the middle of a run, then rerun from SEED.
    applyStimulus(1);
    repeat (499) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_flags", 68'({bus_m.busy, bus_m.done}), 68'(0));
    checkOutput("midrst_count", 68'(bus_m.error_count), 68'(0));
    checkOutput("midrst_ab", 68'({bus_m.a, bus_m.b}), 68'(0));
    rst        = 1'b1;
    model_lfsr = SEED;
    applyStimulus(1);
    runMain(1'b1, cycles);
    checkClean("rerun", cycles);

    // Zero flag stuck at 0: abort on the eleventh error.
    fault_zero = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst        = 1'b1;
    model_lfsr = SEED;
    applyStimulus(1);
    runMain(1'b0, cycles);
    checkOutput("zf_flags",
                68'({bus_m.busy, bus_m.done, bus_m.pass, bus_m.aborted}), 68'(4'b0101));
    checkOutput("zf_count", 68'(bus_m.error_count), 68'(11));
    checkOutput("zf_first",
                {bus_m.first_fail_a, bus_m.first_fail_b, bus_m.first_fail_control},
                first_zero);
    fault_zero = 1'b0;

    // Control-3 result fault with a large limit: full run, only bit 3 flagged.
    @(negedge clk);
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    cycles = 1;
    while (!bus_b.done && cycles < LIMIT) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("op3_cycles", 68'(cycles), 68'(RUN_LEN));
    checkOutput("op3_flags",
                68'({bus_b.busy, bus_b.done, bus_b.pass, bus_b.aborted}), 68'(4'b0100));
    checkOutput("op3_mask", 68'(bus_b.fail_op_mask), 68'(16'h0008));
    checkOutput("op3_count", 68'(bus_b.error_count), 68'(9 * 9 + 25));
    checkOutput("op3_first",
                {bus_b.first_fail_a, bus_b.first_fail_b, bus_b.first_fail_control},
                {vec_rom(4'd0), vec_rom(4'd0), 4'd3});

    // Empty op mask: done and pass one cycle after start, operands untouched.
    checkOutput("empty_idle", 68'({bus_z.busy, bus_z.done}), 68'(0));
    @(negedge clk);
    bus_z.start = 1'b1;
    @(negedge clk);
    bus_z.start = 1'b0;
    checkOutput("empty_flags",
                68'({bus_z.busy, bus_z.done, bus_z.pass, bus_z.aborted}), 68'(4'b0110));
    checkOutput("empty_stim", {bus_z.a, bus_z.b, bus_z.control}, 68'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
